// File: rtl/dmem_ctrl.sv
// Data-memory access controller: one load/store per request, word-wide memory
// with req/ack handshake, big-endian lanes, size extraction and error reporting.
module dmem_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [1:0]        dsize,
   input  logic              loadext,
   output logic              cpu_stall,
   output logic              cpu_done,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_err,
   output logic [1:0]        err_cause,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    l_size;
   logic [1:0]    l_off;
   logic          l_ext;

   logic          bad_size;
   logic          misaligned;
   logic [3:0]    be_next;
   logic [31:0]   wdata_next;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_data;

   // Handshake: cpu_req is held by the datapath until cpu_done; mem_req stays
   // high with stable mem_* fields until mem_ack is sampled or the access times out.
   assign cpu_stall = cpu_req & ~cpu_done;
   assign dbg_state = state;

   assign bad_size   = (dsize == 2'b10);
   assign misaligned = ((dsize == 2'b01) && cpu_addr[0]) ||
                       ((dsize == 2'b11) && (cpu_addr[1:0] != 2'b00));

   always_comb begin
      be_next    = 4'b1111;
      wdata_next = cpu_wdata;
      case (dsize)
         2'b00: begin
            be_next    = 4'b1000 >> cpu_addr[1:0];
            wdata_next = {4{cpu_wdata[7:0]}};
         end
         2'b01: begin
            be_next    = cpu_addr[1] ? 4'b0011 : 4'b1100;
            wdata_next = {2{cpu_wdata[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = cpu_wdata;
         end
      endcase
   end

   // Offset 0 is the most significant lane.
   always_comb begin
      byte_sel = mem_rdata[31:24];
      case (l_off)
         2'd0: byte_sel = mem_rdata[31:24];
         2'd1: byte_sel = mem_rdata[23:16];
         2'd2: byte_sel = mem_rdata[15:8];
         default: byte_sel = mem_rdata[7:0];
      endcase
      half_sel = l_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
      case (l_size)
         2'b00:   load_data = {{24{l_ext & byte_sel[7]}}, byte_sel};
         2'b01:   load_data = {{16{l_ext & half_sel[15]}}, half_sel};
         default: load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         l_size    <= 2'b00;
         l_off     <= 2'b00;
         l_ext     <= 1'b0;
         cpu_done  <= 1'b0;
         cpu_err   <= 1'b0;
         err_cause <= 2'b00;
         cpu_rdata <= 32'h0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 4'b0000;
         mem_wdata <= 32'h0;
      end else begin
         cpu_done <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  if (bad_size) begin
                     state     <= RESP;
                     cpu_done  <= 1'b1;
                     cpu_err   <= 1'b1;
                     err_cause <= 2'b10;
                  end else if (misaligned) begin
                     state     <= RESP;
                     cpu_done  <= 1'b1;
                     cpu_err   <= 1'b1;
                     err_cause <= 2'b01;
                  end else begin
                     state     <= WAIT;
                     cnt       <= '0;
                     l_size    <= dsize;
                     l_off     <= cpu_addr[1:0];
                     l_ext     <= loadext;
                     mem_req   <= 1'b1;
                     mem_we    <= cpu_we;
                     mem_addr  <= cpu_addr[ADDR_W-1:2];
                     mem_be    <= be_next;
                     mem_wdata <= wdata_next;
                  end
               end
            end
            WAIT: begin
               // Ack on the last permitted cycle takes priority over timeout.
               if (mem_ack) begin
                  state     <= RESP;
                  mem_req   <= 1'b0;
                  cpu_done  <= 1'b1;
                  cpu_err   <= 1'b0;
                  err_cause <= 2'b00;
                  if (!mem_we) cpu_rdata <= load_data;
               end else if (cnt == CNT_LAST) begin
                  state     <= RESP;
                  mem_req   <= 1'b0;
                  cpu_done  <= 1'b1;
                  cpu_err   <= 1'b1;
                  err_cause <= 2'b11;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: driver pushes expected responses computed
// from a byte-lane reference model; monitors pop and compare on DUT outputs.
module tb_dmem_ctrl;

   localparam int TO = 4;
   localparam int W  = 67;  // {done_cyc[31:0], err, cause[1:0], rdata[31:0]}
   localparam int MW = 75;  // {len[7:0], we, addr[29:0], be[3:0], wdata[31:0]}

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = 32'h0;
   logic [31:0] cpu_wdata = 32'h0;
   logic [1:0]  dsize = 2'b11;
   logic        loadext = 1'b0;
   logic        cpu_stall, cpu_done, cpu_err;
   logic [31:0] cpu_rdata;
   logic [1:0]  err_cause;
   logic        mem_req, mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ack = 1'b0;
   logic [1:0]  dbg_state;

   dmem_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .dsize(dsize), .loadext(loadext),
      .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .cpu_err(cpu_err), .err_cause(err_cause), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
   );

   // clock / cycle counter
   always #5 clock = ~clock;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   logic [W-1:0]  exp_q[$];
   logic [MW-1:0] exp_mem_q[$];
   logic [31:0]   last_rdata = 32'h0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // memory responder: acks on the ack_delay-th cycle of mem_req (0 = never)
   int          ack_delay = 1;
   logic [31:0] rd_val = 32'h0;
   int          req_cnt = 0;
   always @(negedge clock) begin
      if (mem_req) begin
         req_cnt = req_cnt + 1;
         mem_ack = (ack_delay != 0) && (req_cnt == ack_delay);
      end else begin
         req_cnt = 0;
         mem_ack = 1'($urandom_range(0, 1));
      end
      mem_rdata = (mem_ack && mem_req) ? rd_val : $urandom;
   end

   // monitor
   logic [MW-1:0] cur_mem;
   bit            have_mem = 0;
   int            run = 0;
   always @(negedge clock) begin
      logic [W-1:0] e;
      if (mem_req) begin
         if (!have_mem) begin
            if (exp_mem_q.size() == 0) check("unexpected_mem_req", 1, 0);
            else begin
               cur_mem  = exp_mem_q.pop_front();
               have_mem = 1;
            end
         end
         if (have_mem)
            check("mem_fields", {mem_we, mem_addr, mem_be, mem_wdata}, cur_mem[66:0]);
         run++;
      end else if (run > 0) begin
         if (have_mem) check("mem_req_len", run, cur_mem[74:67]);
         have_mem = 0;
         run = 0;
      end
      if (cpu_done) begin
         if (exp_q.size() == 0) check("unexpected_done", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("done_cycle", cyc, e[66:35]);
            check("err_cause", {cpu_err, err_cause}, e[34:32]);
            check("rdata", cpu_rdata, e[31:0]);
         end
      end
      if (!reset) check("stall", cpu_stall, cpu_req & ~cpu_done);
   end

   function automatic logic [31:0] model_load(input logic [31:0] rd, input int nb,
                                              input int off, input logic ext);
      longint v, mask;
      mask = (longint'(1) << (8 * nb)) - 1;
      v = (longint'(rd) >> (8 * (4 - nb - off))) & mask;
      if (ext && v[8*nb-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [1:0] sz, input logic ext, input int delay,
                            input logic [31:0] rd);
      int nb, off, len;
      logic [1:0]  cause;
      logic [3:0]  be;
      logic [31:0] wl;
      bit got;
      @(posedge clock); #1;
      cpu_we = we; cpu_addr = addr; cpu_wdata = wd; dsize = sz; loadext = ext;
      ack_delay = delay; rd_val = rd; cpu_req = 1'b1;
      nb  = (sz == 2'b11) ? 4 : (sz == 2'b01) ? 2 : 1;
      off = int'(addr[1:0]);
      len = 0;
      if (sz == 2'b10) cause = 2'b10;
      else if (off % nb != 0) cause = 2'b01;
      else begin
         for (int i = 0; i < 4; i++) begin
            be[3-i] = (i >= off) && (i < off + nb);
            wl[8*(3-i) +: 8] = 8'(wd >> (8 * (nb - 1 - (i % nb))));
         end
         if (delay >= 1 && delay <= TO) begin
            len = delay;
            cause = 2'b00;
            if (!we) last_rdata = model_load(rd, nb, off, ext);
         end else begin
            len = TO;
            cause = 2'b11;
         end
         exp_mem_q.push_back({8'(len), we, addr[31:2], be, wl});
      end
      exp_q.push_back({32'(cyc + len + 1), (cause != 2'b00), cause, last_rdata});
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clock);
         if (cpu_done) got = 1;
      end
      if (!got) check("done_timeout", 0, 1);
      @(posedge clock); #1;
      cpu_req = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {cpu_done, cpu_err, err_cause, cpu_rdata, mem_req, mem_we, mem_addr,
                   mem_be, mem_wdata, dbg_state}, '0);
   endtask

   task automatic reset_mid_wait();
      @(posedge clock); #1;
      cpu_we = 1'b0; cpu_addr = 32'h300; dsize = 2'b11; ack_delay = 0; cpu_req = 1'b1;
      exp_mem_q.push_back({8'd2, 1'b0, 30'(32'h300 >> 2), 4'b1111, 32'h0});
      @(posedge clock); #1;   // first WAIT cycle
      @(posedge clock); #1;   // second WAIT cycle
      reset = 1'b1; cpu_req = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      last_rdata = 32'h0;
      check_reset_outputs("reset_mid_wait");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench time limit");
   end

   initial begin
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("reset_state");
      reset = 1'b0;
      // directed cases
      do_access(1'b0, 32'h100, 32'h0, 2'b11, 1'b0, 1, 32'hDEADBEEF);
      do_access(1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 1, 32'h123456F0);
      do_access(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 2, 32'h123456F0);
      do_access(1'b1, 32'h202, 32'h0000ABCD, 2'b01, 1'b0, 3, 32'h0);
      do_access(1'b0, 32'h102, 32'h0, 2'b11, 1'b0, 1, 32'h0);
      do_access(1'b0, 32'h101, 32'h0, 2'b10, 1'b0, 1, 32'h0);
      do_access(1'b0, 32'h104, 32'h0, 2'b11, 1'b0, 0, 32'h0);
      do_access(1'b0, 32'h108, 32'h0, 2'b11, 1'b0, TO, 32'hCAFEF00D);
      do_access(1'b0, 32'h10A, 32'h0, 2'b01, 1'b1, 2, 32'h1234_8001);
      reset_mid_wait();
      do_access(1'b0, 32'h400, 32'h0, 2'b11, 1'b0, 1, 32'h0BADC0DE);
      // randomized accesses
      for (int n = 0; n < 80; n++) begin
         do_access(1'($urandom_range(0, 1)), $urandom, $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, TO + 1), $urandom);
      end
      repeat (5) @(posedge clock);
      #1;
      check("exp_q_empty", exp_q.size(), 0);
      check("exp_mem_q_empty", exp_mem_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
